// File: rtl/psum_drain.sv
// Captures full psum rows into a small row FIFO and streams them out one column
// per beat over valid/ready; captures arriving while the FIFO is full are dropped.
module psum_drain #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int depth   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [col*bw_psum-1:0]     psum_in,
  input  logic                       capture,
  output logic [bw_psum-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(col)-1:0]     out_col,
  output logic                       out_last,
  output logic [$clog2(depth+1)-1:0] level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int cw = $clog2(col);
  localparam int aw = $clog2(depth);
  localparam int lw = $clog2(depth+1);
  localparam logic [cw-1:0] last_col = cw'(col-1);
  localparam logic [lw-1:0] full     = lw'(depth);

  logic [col*bw_psum-1:0] mem [depth];
  logic [col*bw_psum-1:0] head;
  logic [aw-1:0]          wptr, rptr;
  logic [lw-1:0]          count;
  logic [cw-1:0]          ci;
  logic                   beat, pop, push, drop;

  always_comb begin
    out_valid = (count != '0);
    beat      = out_valid & out_ready;
    pop       = beat & (ci == last_col);
    // A final-beat pop frees a slot in the same cycle, so a full FIFO can still accept.
    push      = capture & ((count != full) | pop);
    drop      = capture & ~push;
    head      = mem[rptr];
    out_data  = out_valid ? head[ci*bw_psum +: bw_psum] : '0;
    out_col   = ci;
    out_last  = out_valid & (ci == last_col);
    level     = count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ci       <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + aw'(1);
      if (pop)  rptr <= rptr + aw'(1);
      if (push && !pop)      count <= count + lw'(1);
      else if (pop && !push) count <= count - lw'(1);
      if (beat) ci <= pop ? '0 : ci + cw'(1);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Row storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wptr] <= psum_in;
  end

endmodule

// File: tb/tb_psum_drain.sv
// Bench for psum_drain: directed scenarios plus random traffic, all checked
// against a queue-of-rows reference model.
module tb_psum_drain;

  localparam int COL   = 8;
  localparam int BW    = 20;
  localparam int DEPTH = 4;
  localparam int R     = COL*BW;

  logic          clk = 1'b0;
  logic          reset, capture, out_ready, ovf_clr;
  logic [R-1:0]  psum_in;
  logic [BW-1:0] out_data;
  logic          out_valid, out_last, overflow;
  logic [2:0]    out_col;
  logic [2:0]    level;

  psum_drain #(.col(COL), .bw_psum(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .psum_in(psum_in), .capture(capture),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_col(out_col), .out_last(out_last), .level(level),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: queued rows, current column of head row, sticky flag
  logic [R-1:0]  q[$];
  int            mci = 0;
  logic          movf = 1'b0;
  logic [BW-1:0] seen[$];

  logic [28:0] act;
  assign act = {out_valid, out_data, out_col, out_last, level, overflow};

  function automatic logic [BW-1:0] col_of(input logic [R-1:0] row, input int c);
    return row[c*BW +: BW];
  endfunction

  function automatic logic [28:0] exp_vec();
    logic          v;
    logic [BW-1:0] d;
    v = (q.size() != 0);
    d = '0;
    if (v) d = col_of(q[0], mci);
    return {v, d, 3'(mci), v && (mci == COL-1), 3'(q.size()), movf};
  endfunction

  function automatic logic [R-1:0] rand_row();
    logic [R-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic cycle(input logic cap, input logic [R-1:0] row, input logic rdy,
                       input logic clr, input logic rst);
    bit popped, dropped;
    capture = cap; psum_in = row; out_ready = rdy; ovf_clr = clr; reset = rst;
    if (!rst && out_valid && rdy) seen.push_back(out_data);
    @(posedge clk);
    if (rst) begin
      q.delete(); mci = 0; movf = 1'b0;
    end else begin
      popped = 0; dropped = 0;
      if (q.size() != 0 && rdy) begin
        if (mci == COL-1) begin mci = 0; void'(q.pop_front()); popped = 1; end
        else mci++;
      end
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(row);
        else dropped = 1;
      end
      if (dropped) movf = 1'b1;
      else if (clr) movf = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 1);
    checks++;
    if (act !== 29'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", act, 29'd0);
    end
    checks++;
    if (act !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_single_row();
    logic [R-1:0] row;
    cycle(0, '0, 0, 0, 1);
    for (int c = 0; c < COL; c++) row[c*BW +: BW] = BW'(c+1);
    cycle(1, row, 1, 0, 0);
    for (int c = 0; c < COL; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== BW'(c+1) || out_col !== 3'(c) ||
          out_last !== (c == COL-1) || level !== 3'd1) begin
        errors++;
        $display("FAIL single_row beat %0d: got v=%b d=%0d col=%0d last=%b lvl=%0d expected v=1 d=%0d col=%0d last=%b lvl=1",
                 c, out_valid, out_data, out_col, out_last, level, c+1, c, c == COL-1);
      end
      cycle(0, '0, 1, 0, 0);
    end
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL single_row_empty: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, level);
    end
  endtask

  task automatic test_backpressure();
    logic [R-1:0]  row;
    logic [BW-1:0] pd;
    logic [2:0]    pc;
    logic          stalled;
    cycle(0, '0, 0, 0, 1);
    row = rand_row();
    seen.delete();
    cycle(1, row, 0, 0, 0);
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      stalled = out_valid && (k % 3 != 0);
      pd = out_data; pc = out_col;
      cycle(0, '0, (k % 3 == 0), 0, 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL backpressure_model k=%0d: got %h expected %h", k, act, exp_vec());
      end
      if (stalled) begin
        checks++;
        if (out_data !== pd || out_col !== pc) begin
          errors++; $display("FAIL backpressure_stable k=%0d: got d=%h col=%0d expected d=%h col=%0d",
                             k, out_data, out_col, pd, pc);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || seen.size() != COL) begin
      errors++; $display("FAIL backpressure_count: got v=%b beats=%0d expected v=0 beats=%0d",
                         out_valid, seen.size(), COL);
    end else begin
      for (int c = 0; c < COL; c++) begin
        checks++;
        if (seen[c] !== col_of(row, c)) begin
          errors++; $display("FAIL backpressure_beat %0d: got %h expected %h", c, seen[c], col_of(row, c));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [R-1:0] rows [5];
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      rows[i] = rand_row();
      cycle(1, rows[i], 0, 0, 0);
    end
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_full: got lvl=%0d ovf=%b expected lvl=4 ovf=1", level, overflow);
    end
    seen.delete();
    for (int k = 0; k < 4*COL; k++) begin
      cycle(0, '0, 1, 0, 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL overflow_drain k=%0d: got %h expected %h", k, act, exp_vec());
      end
    end
    checks++;
    if (seen.size() != 4*COL || out_valid !== 1'b0) begin
      errors++; $display("FAIL overflow_count: got beats=%0d v=%b expected beats=%0d v=0",
                         seen.size(), out_valid, 4*COL);
    end else begin
      for (int i = 0; i < 4*COL; i++) begin
        checks++;
        if (seen[i] !== col_of(rows[i/COL], i%COL)) begin
          errors++; $display("FAIL overflow_order beat %0d: got %h expected %h",
                             i, seen[i], col_of(rows[i/COL], i%COL));
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got %b expected 1", overflow);
    end
    cycle(0, '0, 1, 1, 0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop();
    logic [R-1:0] rx;
    cycle(0, '0, 0, 0, 1);
    seen.delete();
    for (int i = 0; i < DEPTH; i++) cycle(1, rand_row(), 0, 0, 0);
    for (int i = 0; i < COL-1; i++) cycle(0, '0, 1, 0, 0);
    rx = rand_row();
    cycle(1, rx, 1, 0, 0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || act !== exp_vec()) begin
      errors++; $display("FAIL full_pop: got lvl=%0d ovf=%b vec=%h expected lvl=4 ovf=0 vec=%h",
                         level, overflow, act, exp_vec());
    end
    for (int k = 0; k < 4*COL; k++) begin
      cycle(0, '0, 1, 0, 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL full_pop_drain k=%0d: got %h expected %h", k, act, exp_vec());
      end
    end
    checks++;
    if (seen.size() != 5*COL) begin
      errors++; $display("FAIL full_pop_count: got %0d expected %0d", seen.size(), 5*COL);
    end else begin
      for (int c = 0; c < COL; c++) begin
        checks++;
        if (seen[4*COL+c] !== col_of(rx, c)) begin
          errors++; $display("FAIL full_pop_row col %0d: got %h expected %h", c, seen[4*COL+c], col_of(rx, c));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [R-1:0] f;
    cycle(0, '0, 0, 0, 1);
    cycle(1, rand_row(), 0, 0, 0);
    cycle(1, rand_row(), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0);
    cycle(1, rand_row(), 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_col !== 3'd0) begin
      errors++; $display("FAIL reset_mid: got v=%b lvl=%0d col=%0d expected v=0 lvl=0 col=0",
                         out_valid, level, out_col);
    end
    f = rand_row();
    cycle(1, f, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_col !== 3'd0 || out_data !== col_of(f, 0)) begin
      errors++; $display("FAIL reset_mid_new: got v=%b col=%0d d=%h expected v=1 col=0 d=%h",
                         out_valid, out_col, out_data, col_of(f, 0));
    end
    for (int k = 0; k < COL; k++) begin
      cycle(0, '0, 1, 0, 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL reset_mid_drain k=%0d: got %h expected %h", k, act, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, '0, 0, 0, 1);
    for (int i = 0; i < 3*COL; i++) begin
      cycle(i < 3, rand_row(), 1, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || out_last !== (i % COL == COL-1) || overflow !== 1'b0 ||
          act !== exp_vec()) begin
        errors++; $display("FAIL back_to_back beat %0d: got v=%b last=%b ovf=%b vec=%h expected v=1 last=%b ovf=0 vec=%h",
                           i, out_valid, out_last, overflow, act, i % COL == COL-1, exp_vec());
      end
    end
    cycle(0, '0, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_back_end: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    cycle(0, '0, 0, 0, 1);
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 5) == 0, rand_row(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random k=%0d: got %h expected %h", k, act, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0; psum_in = '0;
    @(negedge clk);
    test_reset();
    test_single_row();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
